mat_mult_tiled: RTL and testbench

//  Parametrised NxN integer matrix multiplier C = A*B using a TxT array of MACs, computed tile by tile.

---
 rtl/mat_mult_tiled_pkg.sv | 23 ++
 rtl/mat_mult_tiled_mac_cell.sv | 47 ++++
 rtl/mat_mult_tiled.sv | 200 ++++++++++++++++++++
 tb/tb_mat_mult_tiled.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_mult_tiled_pkg.sv
// Shared state encoding and sizing helpers for the tiled matrix multiplier.
package mat_mult_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        MAC   = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Accumulator width that cannot overflow for N products of two DW-bit operands.
    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned n);
        return 2 * dw + int'($clog2(n));
    endfunction

    // Index width for a counter over n values, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/mat_mult_tiled_mac_cell.sv
// One multiply-accumulate lane with synchronous clear, enable and signed/unsigned operand extension.
module mac_cell #(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 19
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic          is_signed,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [CW-1:0] acc_next_c
);

    localparam int unsigned PW = 2 * DW;
    localparam int unsigned XW = CW - PW;

    logic [PW-1:0] a_ext;
    logic [PW-1:0] b_ext;
    logic [PW-1:0] prod;
    logic [CW-1:0] prod_ext;
    logic [CW-1:0] acc;

    // Low PW bits of the extended product are exact in both modes.
    always_comb begin
        a_ext      = is_signed ? {{DW{a[DW-1]}}, a} : {{DW{1'b0}}, a};
        b_ext      = is_signed ? {{DW{b[DW-1]}}, b} : {{DW{1'b0}}, b};
        prod       = a_ext * b_ext;
        prod_ext   = is_signed ? {{XW{prod[PW-1]}}, prod} : {{XW{1'b0}}, prod};
        acc_next_c = acc;
        if (clr) begin
            acc_next_c = '0;
        end else if (en) begin
            acc_next_c = acc + prod_ext;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else begin
            acc <= acc_next_c;
        end
    end

endmodule

// File: rtl/mat_mult_tiled.sv
// Tiled NxN integer matrix multiplier: a TxT MAC array walks C tile by tile, streaming A/B
// from T-port read RAMs and writing each finished tile to C in row-major order.
module mat_mult_tiled
    import mat_mult_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned T  = 2,
    parameter int unsigned DW = 8,
    parameter int unsigned AW = $clog2(N * N),
    parameter int unsigned CW = acc_width(DW, N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            is_signed,
    output logic [T*AW-1:0] a_addr,
    input  logic [T*DW-1:0] a_rdata,
    output logic [T*AW-1:0] b_addr,
    input  logic [T*DW-1:0] b_rdata,
    output logic            c_we,
    output logic [AW-1:0]   c_addr,
    output logic [CW-1:0]   c_wdata,
    output logic            busy,
    output logic            done,
    output logic [15:0]     cycle_cnt
);

    localparam int unsigned NT = N / T;
    localparam int unsigned KW = idx_width(N);
    localparam int unsigned TW = idx_width(T);
    localparam int unsigned IW = idx_width(NT);

    state_t        state;
    state_t        state_next;
    logic [KW-1:0] k;
    logic [KW-1:0] addr_k;
    logic [TW-1:0] wr_r;
    logic [TW-1:0] wr_c;
    logic [TW-1:0] wr_r_next;
    logic [TW-1:0] wr_c_next;
    logic [IW-1:0] ti;
    logic [IW-1:0] tj;
    logic          mode_signed;
    logic          rd_valid;
    logic          start_acc;
    logic          write_last;
    logic          tile_last;
    logic          busy_now;
    logic          acc_clr;
    logic [CW-1:0] acc_next [T][T];

    logic [T*AW-1:0] a_addr_d;
    logic [T*AW-1:0] b_addr_d;
    logic            c_we_d;
    logic [AW-1:0]   c_addr_d;
    logic [CW-1:0]   c_wdata_d;
    logic            busy_d;
    logic            done_d;

    assign start_acc  = (state == IDLE) && start;
    assign write_last = (state == WRITE) && (wr_r == TW'(T - 1)) && (wr_c == TW'(T - 1));
    assign tile_last  = (ti == IW'(NT - 1)) && (tj == IW'(NT - 1));
    assign busy_now   = state inside {CLEAR, MAC, DRAIN, WRITE};
    assign acc_clr    = (state == CLEAR);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = CLEAR;
            CLEAR:   state_next = MAC;
            MAC:     if (k == KW'(N - 1)) state_next = DRAIN;
            DRAIN:   state_next = WRITE;
            WRITE:   if (write_last) state_next = tile_last ? DONE : CLEAR;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: values that the output registers will hold during state_next.
    always_comb begin
        a_addr_d  = '0;
        b_addr_d  = '0;
        c_we_d    = 1'b0;
        c_addr_d  = '0;
        c_wdata_d = '0;
        busy_d    = state_next inside {CLEAR, MAC, DRAIN, WRITE};
        done_d    = (state_next == DONE);
        addr_k    = (state == MAC) ? k + KW'(1) : '0;
        wr_r_next = '0;
        wr_c_next = '0;
        if (state == WRITE) begin
            if (wr_c == TW'(T - 1)) begin
                wr_c_next = '0;
                wr_r_next = wr_r + TW'(1);
            end else begin
                wr_c_next = wr_c + TW'(1);
                wr_r_next = wr_r;
            end
        end
        if (state_next == MAC) begin
            for (int unsigned l = 0; l < T; l++) begin
                a_addr_d[l*AW +: AW] = AW'((32'(ti) * T + l) * N + 32'(addr_k));
                b_addr_d[l*AW +: AW] = AW'(32'(addr_k) * N + 32'(tj) * T + l);
            end
        end
        // Accumulator next-values are final on the DRAIN->WRITE edge and stable afterwards.
        if (state_next == WRITE) begin
            c_we_d    = 1'b1;
            c_addr_d  = AW'((32'(ti) * T + 32'(wr_r_next)) * N + 32'(tj) * T + 32'(wr_c_next));
            c_wdata_d = acc_next[wr_r_next][wr_c_next];
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_addr  <= '0;
            b_addr  <= '0;
            c_we    <= 1'b0;
            c_addr  <= '0;
            c_wdata <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            a_addr  <= a_addr_d;
            b_addr  <= b_addr_d;
            c_we    <= c_we_d;
            c_addr  <= c_addr_d;
            c_wdata <= c_wdata_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Run mode, k/write/tile counters, read-valid pipeline and busy-cycle counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_signed <= 1'b0;
            rd_valid    <= 1'b0;
            k           <= '0;
            wr_r        <= '0;
            wr_c        <= '0;
            ti          <= '0;
            tj          <= '0;
            cycle_cnt   <= '0;
        end else begin
            rd_valid <= (state == MAC);
            k        <= addr_k;
            wr_r     <= wr_r_next;
            wr_c     <= wr_c_next;
            if (start_acc) begin
                mode_signed <= is_signed;
                ti          <= '0;
                tj          <= '0;
                cycle_cnt   <= '0;
            end else begin
                if (busy_now) begin
                    cycle_cnt <= cycle_cnt + 16'd1;
                end
                if (write_last) begin
                    if (tj == IW'(NT - 1)) begin
                        tj <= '0;
                        ti <= ti + IW'(1);
                    end else begin
                        tj <= tj + IW'(1);
                    end
                end
            end
        end
    end

    for (genvar r = 0; r < T; r++) begin : g_row
        for (genvar c = 0; c < T; c++) begin : g_col
            mac_cell #(
                .DW (DW),
                .CW (CW)
            ) u_mac (
                .clk        (clk),
                .reset      (reset),
                .clr        (acc_clr),
                .en         (rd_valid),
                .is_signed  (mode_signed),
                .a          (a_rdata[r*DW +: DW]),
                .b          (b_rdata[c*DW +: DW]),
                .acc_next_c (acc_next[r][c])
            );
        end
    end

endmodule

// File: tb/tb_mat_mult_tiled.sv
// Directed bench for mat_mult_tiled at N=8, T=2: table of uniform/structured matrices plus
// hand-written sequences for start abuse, mode change, back-to-back restart and mid-run reset.
module tb_mat_mult_tiled;

    localparam int unsigned N    = 8;
    localparam int unsigned T    = 2;
    localparam int unsigned DW   = 8;
    localparam int unsigned AW   = 6;
    localparam int unsigned CW   = 19;
    localparam int          LAT  = 225;
    localparam int          CCNT = 224;

    localparam int K_CONST = 0;
    localparam int K_IDENT = 1;
    localparam int K_RAMP  = 2;
    localparam int K_RAND  = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic            is_signed = 1'b0;
    logic [T*AW-1:0] a_addr;
    logic [T*DW-1:0] a_rdata;
    logic [T*AW-1:0] b_addr;
    logic [T*DW-1:0] b_rdata;
    logic            c_we;
    logic [AW-1:0]   c_addr;
    logic [CW-1:0]   c_wdata;
    logic            busy;
    logic            done;
    logic [15:0]     cycle_cnt;

    logic [DW-1:0] amem [N*N];
    logic [DW-1:0] bmem [N*N];
    logic [CW-1:0] cmem [N*N];
    logic [CW-1:0] gold [N*N];

    int checks = 0;
    int failures = 0;
    int n_writes = 0;
    int n_done = 0;
    int n_bus_err = 0;

    typedef struct {
        string         name;
        int            a_kind;
        int            a_val;
        int            b_kind;
        int            b_val;
        logic          sgn;
        logic [CW-1:0] exp_c;
        logic          exp_ramp;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    mat_mult_tiled #(
        .N  (N),
        .T  (T),
        .DW (DW),
        .AW (AW),
        .CW (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .a_addr    (a_addr),
        .a_rdata   (a_rdata),
        .b_addr    (b_addr),
        .b_rdata   (b_rdata),
        .c_we      (c_we),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .busy      (busy),
        .done      (done),
        .cycle_cnt (cycle_cnt)
    );

    // A/B source RAMs with one-cycle read latency.
    always_ff @(posedge clk) begin
        for (int l = 0; l < int'(T); l++) begin
            a_rdata[l*DW +: DW] <= amem[a_addr[l*AW +: AW]];
            b_rdata[l*DW +: DW] <= bmem[b_addr[l*AW +: AW]];
        end
    end

    // C RAM capture and bus-quiet monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (c_we) begin
            cmem[c_addr] = c_wdata;
            n_writes++;
        end else if (c_addr != '0 || c_wdata != '0) begin
            n_bus_err++;
        end
        if (!busy && (a_addr != '0 || b_addr != '0 || c_we)) n_bus_err++;
        if (done && busy) n_bus_err++;
        if (done) n_done++;
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_c(input string name);
        int bad;
        int first;
        bad = 0;
        first = -1;
        for (int i = 0; i < int'(N * N); i++) begin
            if (cmem[i] !== gold[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL c_data %s: %0d wrong elements, C[%0d] got %h expected %h",
                     name, bad, first, cmem[first], gold[first]);
        end
    endtask

    task automatic fill(input int a_kind, input int a_val, input int b_kind, input int b_val);
        for (int i = 0; i < int'(N); i++) begin
            for (int j = 0; j < int'(N); j++) begin
                case (a_kind)
                    K_IDENT: amem[i*N+j] = (i == j) ? DW'(1) : DW'(0);
                    K_RAMP:  amem[i*N+j] = DW'(i * N + j);
                    K_RAND:  amem[i*N+j] = DW'($urandom);
                    default: amem[i*N+j] = DW'(a_val);
                endcase
                case (b_kind)
                    K_IDENT: bmem[i*N+j] = (i == j) ? DW'(1) : DW'(0);
                    K_RAMP:  bmem[i*N+j] = DW'(i * N + j);
                    K_RAND:  bmem[i*N+j] = DW'($urandom);
                    default: bmem[i*N+j] = DW'(b_val);
                endcase
            end
        end
    endtask

    // Reference product, wrapped to CW bits.
    task automatic golden(input logic sgn);
        longint s;
        longint av;
        longint bv;
        for (int i = 0; i < int'(N); i++) begin
            for (int j = 0; j < int'(N); j++) begin
                s = 0;
                for (int k = 0; k < int'(N); k++) begin
                    av = sgn ? longint'($signed(amem[i*N+k])) : longint'(amem[i*N+k]);
                    bv = sgn ? longint'($signed(bmem[k*N+j])) : longint'(bmem[k*N+j]);
                    s += av * bv;
                end
                gold[i*N+j] = CW'(s);
            end
        end
    endtask

    task automatic clear_capture();
        for (int i = 0; i < int'(N * N); i++) cmem[i] = 'x;
        n_writes = 0;
        n_done = 0;
    endtask

    // Start a run and count rising edges from the accepting edge until done is seen.
    task automatic run(input logic sgn, input logic flip_sgn, input logic hold_start,
                       output int lat);
        clear_capture();
        @(negedge clk);
        start = 1'b1;
        is_signed = sgn;
        @(posedge clk);
        #1;
        lat = 1;
        if (!hold_start) start = 1'b0;
        if (flip_sgn) is_signed = ~sgn;
        while (!done && lat < 2000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic check_run(input string name, input int lat);
        @(negedge clk);
        @(negedge clk);
        check({name, " latency"}, lat, LAT);
        check({name, " cycle_cnt"}, cycle_cnt, CCNT);
        check({name, " writes"}, n_writes, 64);
        check({name, " done_pulses"}, n_done, 1);
        check_c(name);
    endtask

    initial begin
        int lat;
        int snap_w;
        int snap_d;

        vecs[0] = '{"ident_ramp_u",  K_IDENT, 0,    K_RAMP,  0,    1'b0, '0,           1'b1};
        vecs[1] = '{"neg128_s",      K_CONST, -128, K_CONST, -128, 1'b1, 19'h20000,    1'b0};
        vecs[2] = '{"all255_u",      K_CONST, 255,  K_CONST, 255,  1'b0, 19'd520200,   1'b0};
        vecs[3] = '{"all255_s",      K_CONST, 255,  K_CONST, 255,  1'b1, 19'd8,        1'b0};
        vecs[4] = '{"three_x_m2_s",  K_CONST, 3,    K_CONST, -2,   1'b1, 19'd524240,   1'b0};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst c_we", c_we, 0);
        check("rst a_addr", a_addr, 0);
        check("rst cycle_cnt", cycle_cnt, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            fill(vecs[v].a_kind, vecs[v].a_val, vecs[v].b_kind, vecs[v].b_val);
            for (int i = 0; i < int'(N * N); i++) gold[i] = vecs[v].exp_ramp ? CW'(i) : vecs[v].exp_c;
            run(vecs[v].sgn, 1'b0, 1'b0, lat);
            check_run(vecs[v].name, lat);
        end

        // Random signed data with is_signed flipped right after accept.
        fill(K_RAND, 0, K_RAND, 0);
        golden(1'b1);
        run(1'b1, 1'b1, 1'b0, lat);
        check_run("rand_s_flip", lat);

        // Random unsigned data with start held high for the whole run.
        fill(K_RAND, 0, K_RAND, 0);
        golden(1'b0);
        run(1'b0, 1'b0, 1'b1, lat);
        check_run("rand_u_hold", lat);
        repeat (3) @(negedge clk);
        check("hold idle busy", busy, 0);
        check("hold extra done", n_done, 1);

        // Start kept high through done re-launches immediately from IDLE.
        clear_capture();
        @(negedge clk);
        start = 1'b1;
        is_signed = 1'b0;
        lat = 0;
        @(posedge clk);
        while (!done && lat < 2000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b first done", done, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("b2b relaunch busy", busy, 1);
        start = 1'b0;
        n_writes = 0;
        lat = 0;
        while (!done && lat < 2000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        @(negedge clk);
        check("b2b second writes", n_writes, 64);
        check_c("b2b_second");

        // Reset in the middle of tile 5's MAC phase, then a clean rerun.
        fill(K_RAND, 0, K_RAND, 0);
        golden(1'b1);
        clear_capture();
        @(negedge clk);
        start = 1'b1;
        is_signed = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (75) @(posedge clk);
        #1;
        check("pre-reset busy", busy, 1);
        reset = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort a_addr", a_addr | b_addr, 0);
        check("abort cycle_cnt", cycle_cnt, 0);
        check("abort c_we", c_we, 0);
        snap_w = n_writes;
        snap_d = n_done;
        repeat (20) @(negedge clk);
        check("abort no writes", n_writes, snap_w);
        check("abort no done", n_done, snap_d);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        run(1'b1, 1'b0, 1'b0, lat);
        check_run("after_reset", lat);

        check("bus quiet violations", n_bus_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
